// File: rtl/fp32_to_int32_seq_pkg.sv
// ============================================================================
// Module  : fp32_to_int32_seq_pkg
// Brief   : Shared fp32 field sizes, integer limits, FSM states and the
//           operand classification record.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32_to_int32_seq_pkg;

  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_W   = 8;
  localparam int          FP_MAN_W   = 23;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] INT_MAX    = 32'h7FFFFFFF;
  localparam logic [31:0] INT_MIN    = 32'h80000000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_nan;
    logic       is_inf;
    logic       is_zero_or_small;
    logic       is_sat;
    logic       is_min_exact;
    logic       dir;              // 1 = shift left, 0 = shift right
    logic [4:0] cnt;
  } class_t;

endpackage

`default_nettype wire

// File: rtl/fp32_to_int32_seq_classify.sv
// ============================================================================
// Module  : fp32_to_int32_seq_classify
// Brief   : Combinational decode of a packed fp32 operand into special-case
//           flags and the alignment direction/distance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_to_int32_seq_classify
  import fp32_to_int32_seq_pkg::*;
(
  input  logic [31:0] a,
  output class_t      cls
);

  localparam logic [7:0] c_bias  = 8'(FP_BIAS);
  localparam logic [7:0] c_sat   = 8'(FP_BIAS + 31);
  localparam logic [7:0] c_align = 8'(FP_BIAS + FP_MAN_W);

  logic                w_sign;
  logic [FP_EXP_W-1:0] w_exp;
  logic [FP_MAN_W-1:0] w_man;

  assign w_sign = a[31];
  assign w_exp  = a[30:23];
  assign w_man  = a[22:0];

  always_comb begin
    cls                  = '0;
    cls.is_nan           = (w_exp == FP_EXP_MAX) && (w_man != '0);
    cls.is_inf           = (w_exp == FP_EXP_MAX) && (w_man == '0);
    cls.is_zero_or_small = (w_exp < c_bias);
    cls.is_sat           = (w_exp >= c_sat) && (w_exp != FP_EXP_MAX);
    cls.is_min_exact     = w_sign && (w_exp == c_sat) && (w_man == '0);
    cls.dir              = (w_exp >= c_align);
    // Distance is below 32 in the normal range, so modulo-32 arithmetic is exact.
    cls.cnt              = cls.dir ? (w_exp[4:0] - c_align[4:0])
                                   : (c_align[4:0] - w_exp[4:0]);
  end

endmodule

`default_nettype wire

// File: rtl/fp32_to_int32_seq.sv
// ============================================================================
// Module  : fp32_to_int32_seq
// Brief   : Iterative fp32 -> int32 converter (round toward zero), aligning
//           the significand one bit per clock with a start/busy/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_to_int32_seq
  import fp32_to_int32_seq_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h7FFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  output logic        busy,
  output logic        done,
  output logic [31:0] Q,
  output logic        ovf,
  output logic        inv
);

  class_t w_cls;

  state_t      r_state, w_state_nxt;
  logic        r_sign,  w_sign_nxt;
  logic        r_dir,   w_dir_nxt;
  logic [4:0]  r_cnt,   w_cnt_nxt;
  logic [31:0] r_mag,   w_mag_nxt;
  logic [31:0] r_q,     w_q_nxt;
  logic        r_ovf,   w_ovf_nxt;
  logic        r_inv,   w_inv_nxt;

  fp32_to_int32_seq_classify u_classify (
    .a   (A),
    .cls (w_cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_dir   <= 1'b0;
      r_cnt   <= '0;
      r_mag   <= '0;
      r_q     <= '0;
      r_ovf   <= 1'b0;
      r_inv   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_dir   <= w_dir_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mag   <= w_mag_nxt;
      r_q     <= w_q_nxt;
      r_ovf   <= w_ovf_nxt;
      r_inv   <= w_inv_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_dir_nxt   = r_dir;
    w_cnt_nxt   = r_cnt;
    w_mag_nxt   = r_mag;
    w_q_nxt     = r_q;
    w_ovf_nxt   = r_ovf;
    w_inv_nxt   = r_inv;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_sign_nxt  = A[31];
          w_state_nxt = S_DONE;
          w_ovf_nxt   = 1'b0;
          w_inv_nxt   = 1'b0;
          if (w_cls.is_nan) begin
            w_q_nxt   = NAN_VALUE;
            w_inv_nxt = 1'b1;
          end else if (w_cls.is_inf) begin
            w_q_nxt   = A[31] ? INT_MIN : INT_MAX;
            w_ovf_nxt = 1'b1;
          end else if (w_cls.is_zero_or_small) begin
            w_q_nxt   = '0;
          end else if (w_cls.is_sat) begin
            // -2^31 is the one exponent-31 value that still fits.
            w_q_nxt   = (A[31] && !w_cls.is_min_exact) ? INT_MIN :
                        (w_cls.is_min_exact ? INT_MIN : INT_MAX);
            w_ovf_nxt = !w_cls.is_min_exact;
          end else begin
            w_state_nxt = S_SHIFT;
            w_ovf_nxt   = r_ovf;
            w_inv_nxt   = r_inv;
            w_mag_nxt   = {8'b0, 1'b1, A[22:0]};
            w_dir_nxt   = w_cls.dir;
            w_cnt_nxt   = w_cls.cnt;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt != 5'd0) begin
          w_mag_nxt = r_dir ? {r_mag[30:0], 1'b0} : {1'b0, r_mag[31:1]};
          w_cnt_nxt = r_cnt - 5'd1;
        end else begin
          w_q_nxt     = r_sign ? (~r_mag + 32'd1) : r_mag;
          w_ovf_nxt   = 1'b0;
          w_inv_nxt   = 1'b0;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign Q    = r_q;
  assign ovf  = r_ovf;
  assign inv  = r_inv;

endmodule

`default_nettype wire
